// File: rtl/uncached_req_buffer.sv
`timescale 1ns/1ps
// Uncached request buffer: posts stores through a DEPTH-entry FIFO and issues single-beat bus
// transactions in program order. Define UC_WBUF_MERGE_EN to merge same-word stores into the tail.
module uncached_req_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [3:0]  req_strobe,
    input  logic [31:0] req_wdata,
    output logic        req_addr_ok,
    output logic        req_data_ok,
    output logic [31:0] req_rdata,
    output logic        bus_valid,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [2:0]  bus_size,
    output logic [3:0]  bus_strobe,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // state | meaning
    // IDLE  | nothing on the bus; drain the FIFO first, otherwise take a load
    // WRITE | FIFO head presented on the bus until bus_ready
    // READ  | load presented on the bus until bus_ready
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t state_q, state_d;

    logic [31:0] fifo_addr_q   [DEPTH];
    logic [2:0]  fifo_size_q   [DEPTH];
    logic [3:0]  fifo_strobe_q [DEPTH];
    logic [31:0] fifo_wdata_q  [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, head_sel;
    logic [CW-1:0] count_q, count_d;

    logic          ent_we;
    logic [PW-1:0] ent_idx;
    logic [31:0]   ent_addr_d, ent_wdata_d;
    logic [2:0]    ent_size_d;
    logic [3:0]    ent_strobe_d;

    logic        bus_valid_q, bus_valid_d, bus_write_q, bus_write_d;
    logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [2:0]  bus_size_q, bus_size_d;
    logic [3:0]  bus_strobe_q, bus_strobe_d;
    logic        req_data_ok_q, req_data_ok_d;
    logic [31:0] req_rdata_q, req_rdata_d;

    logic empty, full, store_req, store_acc, load_acc, push, pop, merge;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign store_req = req_valid & req_write;
    assign pop       = (state_q == WRITE) & bus_ready;

`ifdef UC_WBUF_MERGE_EN
    logic [PW-1:0] tail_idx;
    logic          tail_on_bus;

    assign tail_idx = wr_ptr_q - PW'(1);
    // tail is, or is about to become, the bus entry: merging then would change data under the bus
    assign tail_on_bus = (count_q == CW'(1)) | (pop & (count_q == CW'(2)));
    assign merge = store_req & !empty & !tail_on_bus
                   & (req_addr[31:2] == fifo_addr_q[tail_idx][31:2]);
`else
    assign merge = 1'b0;
`endif

    assign store_acc   = store_req & (!full | merge);
    assign load_acc    = req_valid & !req_write & empty & (state_q == IDLE);
    assign push        = store_acc & !merge;
    assign req_addr_ok = store_acc | load_acc;

    always_comb begin
        ent_we       = store_acc;
        ent_idx      = wr_ptr_q;
        ent_addr_d   = req_addr;
        ent_size_d   = req_size;
        ent_strobe_d = req_strobe;
        ent_wdata_d  = req_wdata;
`ifdef UC_WBUF_MERGE_EN
        if (merge) begin
            ent_idx      = tail_idx;
            ent_addr_d   = fifo_addr_q[tail_idx];
            ent_size_d   = 3'd2;
            ent_strobe_d = fifo_strobe_q[tail_idx] | req_strobe;
            for (int b = 0; b < 4; b++) begin
                ent_wdata_d[8*b +: 8] = req_strobe[b] ? req_wdata[8*b +: 8]
                                                      : fifo_wdata_q[tail_idx][8*b +: 8];
            end
        end
`endif
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    assign head_sel = (state_q == WRITE) ? rd_ptr_q + PW'(1) : rd_ptr_q;

    always_comb begin
        state_d       = state_q;
        bus_valid_d   = bus_valid_q;
        bus_write_d   = bus_write_q;
        bus_addr_d    = bus_addr_q;
        bus_size_d    = bus_size_q;
        bus_strobe_d  = bus_strobe_q;
        bus_wdata_d   = bus_wdata_q;
        req_data_ok_d = store_acc | ((state_q == READ) & bus_ready);
        req_rdata_d   = req_rdata_q;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d      = WRITE;
                    bus_valid_d  = 1'b1;
                    bus_write_d  = 1'b1;
                    bus_addr_d   = fifo_addr_q[head_sel];
                    bus_size_d   = fifo_size_q[head_sel];
                    bus_strobe_d = fifo_strobe_q[head_sel];
                    bus_wdata_d  = fifo_wdata_q[head_sel];
                end else if (load_acc) begin
                    state_d      = READ;
                    bus_valid_d  = 1'b1;
                    bus_write_d  = 1'b0;
                    bus_addr_d   = req_addr;
                    bus_size_d   = req_size;
                    bus_strobe_d = req_strobe;
                    bus_wdata_d  = req_wdata;
                end else begin
                    bus_valid_d = 1'b0;
                end
            end
            WRITE: begin
                if (bus_ready) begin
                    if (count_q > CW'(1)) begin
                        bus_addr_d   = fifo_addr_q[head_sel];
                        bus_size_d   = fifo_size_q[head_sel];
                        bus_strobe_d = fifo_strobe_q[head_sel];
                        bus_wdata_d  = fifo_wdata_q[head_sel];
                    end else if (push) begin
                        // the only remaining entry is being written this edge; take it from the request
                        bus_addr_d   = req_addr;
                        bus_size_d   = req_size;
                        bus_strobe_d = req_strobe;
                        bus_wdata_d  = req_wdata;
                    end else begin
                        state_d     = IDLE;
                        bus_valid_d = 1'b0;
                    end
                end
            end
            READ: begin
                if (bus_ready) begin
                    state_d     = IDLE;
                    bus_valid_d = 1'b0;
                    req_rdata_d = bus_rdata;
                end
            end
            default: begin
                state_d     = IDLE;
                bus_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            bus_valid_q   <= 1'b0;
            bus_write_q   <= 1'b0;
            bus_addr_q    <= '0;
            bus_size_q    <= '0;
            bus_strobe_q  <= '0;
            bus_wdata_q   <= '0;
            req_data_ok_q <= 1'b0;
            req_rdata_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i]   <= '0;
                fifo_size_q[i]   <= '0;
                fifo_strobe_q[i] <= '0;
                fifo_wdata_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            bus_valid_q   <= bus_valid_d;
            bus_write_q   <= bus_write_d;
            bus_addr_q    <= bus_addr_d;
            bus_size_q    <= bus_size_d;
            bus_strobe_q  <= bus_strobe_d;
            bus_wdata_q   <= bus_wdata_d;
            req_data_ok_q <= req_data_ok_d;
            req_rdata_q   <= req_rdata_d;
            if (ent_we) begin
                fifo_addr_q[ent_idx]   <= ent_addr_d;
                fifo_size_q[ent_idx]   <= ent_size_d;
                fifo_strobe_q[ent_idx] <= ent_strobe_d;
                fifo_wdata_q[ent_idx]  <= ent_wdata_d;
            end
        end
    end

    assign req_data_ok = req_data_ok_q;
    assign req_rdata   = req_rdata_q;
    assign bus_valid   = bus_valid_q;
    assign bus_write   = bus_write_q;
    assign bus_addr    = bus_addr_q;
    assign bus_size    = bus_size_q;
    assign bus_strobe  = bus_strobe_q;
    assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_uncached_req_buffer.sv
`timescale 1ns/1ps
// Scoreboard bench for uncached_req_buffer; expected bus transactions are queued as stores and
// loads are driven, and compared against the transactions the bus monitor records.
module tb_uncached_req_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic [3:0]  req_strobe;
    logic        req_addr_ok, req_data_ok;
    logic [31:0] req_rdata;
    logic        bus_valid, bus_write;
    logic [31:0] bus_addr, bus_wdata;
    logic [2:0]  bus_size;
    logic [3:0]  bus_strobe;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strb;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];
    txn_t obs_q[$];
    int   obs_idx = 0;
    int   checks = 0;
    int   errors = 0;
    int   stab_err = 0;
    logic prev_stall = 1'b0;
    txn_t prev_txn;
    txn_t cur_txn;

    localparam logic [31:0] M_ADDR [6] = '{32'h1FAF_2100, 32'h1FAF_2020, 32'h1FAF_2022,
                                           32'h1FAF_2030, 32'h1FAF_2040, 32'h1FAF_2041};
    localparam logic [3:0]  M_STRB [6] = '{4'b0001, 4'b0001, 4'b0100, 4'b0001, 4'b0001, 4'b0010};
    localparam logic [31:0] M_DATA [6] = '{32'h0000_00F0, 32'h0000_0011, 32'h0033_0000,
                                           32'h0000_00A0, 32'h0000_00C0, 32'h0000_DD00};
`ifdef UC_WBUF_MERGE_EN
    localparam bit M_CHK [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam bit M_OK  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`else
    localparam bit M_CHK [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam bit M_OK  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif

    always #5 clk = ~clk;

    uncached_req_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_strobe  (req_strobe),
        .req_wdata   (req_wdata),
        .req_addr_ok (req_addr_ok),
        .req_data_ok (req_data_ok),
        .req_rdata   (req_rdata),
        .bus_valid   (bus_valid),
        .bus_write   (bus_write),
        .bus_addr    (bus_addr),
        .bus_size    (bus_size),
        .bus_strobe  (bus_strobe),
        .bus_wdata   (bus_wdata),
        .bus_ready   (bus_ready),
        .bus_rdata   (bus_rdata)
    );

    assign cur_txn = {bus_write, bus_addr, bus_size, bus_strobe, bus_wdata};

    // bus monitor: records completed transactions and flags any change while stalled
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!bus_valid || cur_txn !== prev_txn)) stab_err <= stab_err + 1;
            prev_stall <= bus_valid && !bus_ready;
            prev_txn   <= cur_txn;
            if (bus_valid && bus_ready) obs_q.push_back(cur_txn);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_req();
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_size   = '0;
        req_strobe = '0;
        req_wdata  = '0;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [2:0] s,
                               input logic [3:0] st, input logic [31:0] d);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = a;
        req_size   = s;
        req_strobe = st;
        req_wdata  = d;
    endtask

    task automatic test_reset();
        int bad;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_bus_valid: got %b required 0", bus_valid); end
        checks++;
        if (req_data_ok !== 1'b0 || req_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_req_outputs: got ok=%b rdata=%h required 0/0", req_data_ok, req_rdata);
        end
        checks++;
        if (bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_strobe !== 4'h0) begin
            errors++; $display("FAIL reset_bus_fields: got %h/%h/%h required zeros", bus_addr, bus_wdata, bus_strobe);
        end
        reset = 1'b0;
        tick();
        drive_store(32'h1FAF_0F00, 3'd2, 4'hF, 32'hCAFE_F00D);
        tick();
        idle_req();
        for (int i = 0; i < 10 && !bus_valid; i++) tick();
        checks++;
        if (bus_valid !== 1'b1) begin errors++; $display("FAIL reset_reach_write: got bus_valid=%b required 1", bus_valid); end
        reset = 1'b1;
        #1;
        checks++;
        if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_async_drop: got bus_valid=%b required 0", bus_valid); end
        repeat (2) tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (req_data_ok !== 1'b0 || bus_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_discard: got %0d active cycles required 0", bad); end
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h1FAF_0F10;
        #1;
        checks++;
        if (req_addr_ok !== 1'b1) begin errors++; $display("FAIL reset_fifo_empty: got load addr_ok=%b required 1", req_addr_ok); end
        idle_req();
    endtask

    task automatic test_single_store();
        txn_t e, o;
        drive_store(32'h1FD0_03F8, 3'd0, 4'b0001, 32'h0000_0041);
        #1;
        checks++;
        if (req_addr_ok !== 1'b1) begin errors++; $display("FAIL single_addr_ok: got %b required 1", req_addr_ok); end
        exp_q.push_back({1'b1, 32'h1FD0_03F8, 3'd0, 4'b0001, 32'h0000_0041});
        tick();
        idle_req();
        checks++;
        if (req_data_ok !== 1'b1) begin errors++; $display("FAIL single_data_ok: got %b required 1", req_data_ok); end
        tick();
        checks++;
        if (req_data_ok !== 1'b0) begin errors++; $display("FAIL single_data_ok_pulse: got %b required 0", req_data_ok); end
        checks++;
        if (bus_valid !== 1'b1 || bus_write !== 1'b1 || bus_addr !== 32'h1FD0_03F8 || bus_strobe !== 4'b0001
            || bus_wdata !== 32'h41 || bus_size !== 3'd0) begin
            errors++; $display("FAIL single_bus_fields: got v=%b w=%b a=%h s=%b d=%h required 1 1 1fd003f8 0001 00000041",
                               bus_valid, bus_write, bus_addr, bus_strobe, bus_wdata);
        end
        tick();
        checks++;
        if (bus_valid !== 1'b1 || bus_addr !== 32'h1FD0_03F8 || bus_wdata !== 32'h41) begin
            errors++; $display("FAIL single_bus_hold: got v=%b a=%h d=%h required 1 1fd003f8 00000041", bus_valid, bus_addr, bus_wdata);
        end
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        checks++;
        if (bus_valid !== 1'b0) begin errors++; $display("FAIL single_bus_done: got bus_valid=%b required 0", bus_valid); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_idx >= obs_q.size()) begin
                errors++; $display("FAIL single_sb_missing: got nothing required %h", e);
            end else begin
                o = obs_q[obs_idx];
                obs_idx++;
                if (o !== e) begin errors++; $display("FAIL single_sb_txn: got %h required %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != obs_idx) begin errors++; $display("FAIL single_sb_extra: got %0d txns required %0d", obs_q.size(), obs_idx); end
    endtask

    task automatic test_fill_full();
        txn_t e, o;
        int bad;
        logic acc;
        bus_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_store(32'h1FAF_0000 + 32'(4 * i), 3'd2, 4'hF, 32'hA000_0000 + 32'(i));
            #1;
            if (req_addr_ok !== 1'b1) bad++;
            exp_q.push_back({1'b1, 32'h1FAF_0000 + 32'(4 * i), 3'd2, 4'hF, 32'hA000_0000 + 32'(i)});
            tick();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL fill_accept: got %0d refusals required 0", bad); end
        drive_store(32'h1FAF_0010, 3'd2, 4'hF, 32'hA000_0004);
        #1;
        checks++;
        if (req_addr_ok !== 1'b0) begin errors++; $display("FAIL fill_full_block: got addr_ok=%b required 0", req_addr_ok); end
        bus_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            tick();
            if (req_addr_ok === 1'b1) acc = 1'b1;
        end
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL fill_late_accept: got addr_ok=0 for 20 cycles required 1"); end
        exp_q.push_back({1'b1, 32'h1FAF_0010, 3'd2, 4'hF, 32'hA000_0004});
        tick();
        idle_req();
        for (int i = 0; i < 100 && (bus_valid || obs_q.size() < obs_idx + exp_q.size()); i++) tick();
        bus_ready = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_idx >= obs_q.size()) begin
                errors++; $display("FAIL fill_sb_missing: got nothing required %h", e);
            end else begin
                o = obs_q[obs_idx];
                obs_idx++;
                if (o !== e) begin errors++; $display("FAIL fill_sb_txn: got %h required %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != obs_idx) begin errors++; $display("FAIL fill_sb_extra: got %0d txns required %0d", obs_q.size(), obs_idx); end
    endtask

    task automatic test_load_after_stores();
        txn_t e, o;
        logic acc;
        bus_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_store(32'h1FAF_0020 + 32'(4 * i), 3'd2, 4'hF, 32'h0000_0001 + 32'(i));
            #1;
            checks++;
            if (req_addr_ok !== 1'b1) begin errors++; $display("FAIL load_pre_store: got addr_ok=%b required 1", req_addr_ok); end
            exp_q.push_back({1'b1, 32'h1FAF_0020 + 32'(4 * i), 3'd2, 4'hF, 32'h0000_0001 + 32'(i)});
            tick();
        end
        idle_req();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h1FAF_0010;
        req_size  = 3'd2;
        #1;
        checks++;
        if (req_addr_ok !== 1'b0) begin errors++; $display("FAIL load_held: got addr_ok=%b required 0", req_addr_ok); end
        bus_ready = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        acc = 1'b0;
        for (int i = 0; i < 30 && !acc; i++) begin
            tick();
            if (req_addr_ok === 1'b1) acc = 1'b1;
        end
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL load_accept: got addr_ok=0 for 30 cycles required 1"); end
        checks++;
        if (obs_q.size() - obs_idx != 2) begin
            errors++; $display("FAIL load_order: got %0d writes done at accept required 2", obs_q.size() - obs_idx);
        end
        exp_q.push_back({1'b0, 32'h1FAF_0010, 3'd2, 4'h0, 32'h0});
        tick();
        idle_req();
        checks++;
        if (bus_valid !== 1'b1 || bus_write !== 1'b0 || bus_addr !== 32'h1FAF_0010) begin
            errors++; $display("FAIL load_bus_read: got v=%b w=%b a=%h required 1 0 1faf0010", bus_valid, bus_write, bus_addr);
        end
        tick();
        bus_ready = 1'b0;
        checks++;
        if (req_data_ok !== 1'b1) begin errors++; $display("FAIL load_data_ok: got %b required 1", req_data_ok); end
        checks++;
        if (req_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata: got %h required deadbeef", req_rdata); end
        tick();
        checks++;
        if (req_data_ok !== 1'b0 || bus_valid !== 1'b0) begin
            errors++; $display("FAIL load_complete: got ok=%b v=%b required 0 0", req_data_ok, bus_valid);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_idx >= obs_q.size()) begin
                errors++; $display("FAIL load_sb_missing: got nothing required %h", e);
            end else begin
                o = obs_q[obs_idx];
                obs_idx++;
                if (o.wr !== e.wr || o.addr !== e.addr
                    || (e.wr && (o.size !== e.size || o.strb !== e.strb || o.data !== e.data))) begin
                    errors++; $display("FAIL load_sb_txn: got %h required %h", o, e);
                end
            end
        end
        checks++;
        if (obs_q.size() != obs_idx) begin errors++; $display("FAIL load_sb_extra: got %0d txns required %0d", obs_q.size(), obs_idx); end
    endtask

    task automatic test_back_to_back_wrap();
        txn_t e, o;
        int idx;
        idx = 0;
        for (int cyc = 0; cyc < 200 && (idx < 10 || bus_valid || obs_q.size() < obs_idx + exp_q.size()); cyc++) begin
            bus_ready = ((cyc % 2) == 1);
            if (idx < 10) begin
                drive_store(32'h1FAF_1000 + 32'(4 * idx), 3'd2, 4'hF, 32'h5000_0000 + 32'(idx));
                #1;
                if (req_addr_ok === 1'b1) begin
                    exp_q.push_back({1'b1, 32'h1FAF_1000 + 32'(4 * idx), 3'd2, 4'hF, 32'h5000_0000 + 32'(idx)});
                    idx++;
                end
            end else begin
                idle_req();
            end
            tick();
        end
        idle_req();
        bus_ready = 1'b0;
        checks++;
        if (idx != 10) begin errors++; $display("FAIL wrap_accepted: got %0d stores required 10", idx); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_idx >= obs_q.size()) begin
                errors++; $display("FAIL wrap_sb_missing: got nothing required %h", e);
            end else begin
                o = obs_q[obs_idx];
                obs_idx++;
                if (o !== e) begin errors++; $display("FAIL wrap_sb_txn: got %h required %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != obs_idx) begin errors++; $display("FAIL wrap_sb_extra: got %0d txns required %0d", obs_q.size(), obs_idx); end
    endtask

    task automatic test_merge();
        txn_t e, o;
        logic acc;
        bus_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_store(M_ADDR[i], 3'd0, M_STRB[i], M_DATA[i]);
            #1;
            if (M_CHK[i]) begin
                checks++;
                if (req_addr_ok !== M_OK[i]) begin
                    errors++; $display("FAIL merge_addr_ok[%0d]: got %b required %b", i, req_addr_ok, M_OK[i]);
                end
            end
            if (req_addr_ok !== 1'b1) begin
                bus_ready = 1'b1;
                acc = 1'b0;
                for (int k = 0; k < 20 && !acc; k++) begin
                    tick();
                    if (req_addr_ok === 1'b1) acc = 1'b1;
                end
                checks++;
                if (acc !== 1'b1) begin errors++; $display("FAIL merge_late_accept[%0d]: got addr_ok=0 required 1", i); end
            end
            tick();
            bus_ready = 1'b0;
        end
        idle_req();
`ifdef UC_WBUF_MERGE_EN
        exp_q.push_back({1'b1, 32'h1FAF_2100, 3'd0, 4'b0001, 32'h0000_00F0});
        exp_q.push_back({1'b1, 32'h1FAF_2020, 3'd2, 4'b0101, 32'h0033_0011});
        exp_q.push_back({1'b1, 32'h1FAF_2030, 3'd0, 4'b0001, 32'h0000_00A0});
        exp_q.push_back({1'b1, 32'h1FAF_2040, 3'd2, 4'b0011, 32'h0000_DDC0});
`else
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b1, M_ADDR[i], 3'd0, M_STRB[i], M_DATA[i]});
`endif
        bus_ready = 1'b1;
        for (int i = 0; i < 100 && (bus_valid || obs_q.size() < obs_idx + exp_q.size()); i++) tick();
        bus_ready = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_idx >= obs_q.size()) begin
                errors++; $display("FAIL merge_sb_missing: got nothing required %h", e);
            end else begin
                o = obs_q[obs_idx];
                obs_idx++;
                if (o !== e) begin errors++; $display("FAIL merge_sb_txn: got %h required %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != obs_idx) begin errors++; $display("FAIL merge_sb_extra: got %0d txns required %0d", obs_q.size(), obs_idx); end
    endtask

    task automatic test_bus_stability();
        tick();
        checks++;
        if (stab_err != 0) begin errors++; $display("FAIL bus_stability: got %0d changes while stalled required 0", stab_err); end
    endtask

    initial begin
        reset     = 1'b1;
        bus_ready = 1'b0;
        bus_rdata = '0;
        idle_req();
        test_reset();
        test_single_store();
        test_fill_full();
        test_load_after_stores();
        test_back_to_back_wrap();
        test_merge();
        test_bus_stability();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
